// File: rtl/sdram_cmd_sequencer_pkg.sv
// Shared SDRAM command encodings, address-field widths and sequencer state encoding.
// Used by both the power-up initializer and the post-init command sequencer.
package sdram_cmd_sequencer_pkg;

    localparam int ROW_W  = 13;
    localparam int BANK_W = 2;
    localparam int COL_W  = 10;
    localparam int ADDR_W = 13;
    localparam int REQ_W  = ROW_W + BANK_W + COL_W;
    localparam int TMR_W  = 4;
    localparam int REFI_W = 11;

    // {RAS, CAS, WE}
    localparam logic [2:0] CMD_NOOP = 3'b111;
    localparam logic [2:0] CMD_ACTV = 3'b011;
    localparam logic [2:0] CMD_READ = 3'b101;
    localparam logic [2:0] CMD_WRIT = 3'b100;
    localparam logic [2:0] CMD_PRCH = 3'b010;
    localparam logic [2:0] CMD_ARSR = 3'b001;
    localparam logic [2:0] CMD_MRST = 3'b000;

    localparam logic [ADDR_W-1:0] ARSR_ADDR = 13'h200;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ACT,
        ST_RCD_WAIT,
        ST_RW,
        ST_RC_WAIT,
        ST_REF,
        ST_RFC_WAIT
    } state_t;

    // A10 set selects auto-precharge on the column command.
    function automatic logic [ADDR_W-1:0] rw_address(input logic [COL_W-1:0] col);
        return {2'b00, 1'b1, col};
    endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval timer: free-runs while enabled, raises a pending refresh at each wrap
// and flags a sticky overrun when a wrap finds the previous refresh still pending.
module sdram_refresh_timer
    import sdram_cmd_sequencer_pkg::*;
#(
    parameter int T_REFI = 1560
) (
    input  logic CLK_n,
    input  logic RST,
    input  logic enable,
    input  logic clear,
    output logic wrap,
    output logic pending,
    output logic overrun
);

    localparam logic [REFI_W-1:0] REFI_LAST = REFI_W'(T_REFI - 1);

    logic [REFI_W-1:0] refi_cnt;

    assign wrap = enable && (refi_cnt == REFI_LAST);

    always_ff @(posedge CLK_n) begin
        if (RST) begin
            refi_cnt <= '0;
            pending  <= 1'b0;
            overrun  <= 1'b0;
        end else begin
            if (!enable || wrap) begin
                refi_cnt <= '0;
            end else begin
                refi_cnt <= refi_cnt + 1'b1;
            end
            // A wrap coinciding with the ARSR issue opens a fresh interval, so it wins.
            if (wrap) begin
                pending <= 1'b1;
            end else if (clear) begin
                pending <= 1'b0;
            end
            if (wrap && pending) begin
                overrun <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/sdram_cmd_sequencer.sv
// Post-init SDRAM command sequencer: single-beat requests become ACTV -> READ/WRIT (auto-precharge),
// with periodic auto-refresh inserted between sequences. All outputs are registered.
module sdram_cmd_sequencer
    import sdram_cmd_sequencer_pkg::*;
#(
    parameter int T_RCD  = 2,
    parameter int T_RC   = 7,
    parameter int T_RFC  = 10,
    parameter int T_REFI = 1560
) (
    input  logic              CLK_n,
    input  logic              RST,
    input  logic              INIT_DONE,
    input  logic              REQ_VALID,
    output logic              REQ_READY,
    input  logic              REQ_WE,
    input  logic [REQ_W-1:0]  REQ_ADDR,
    output logic [2:0]        COMMAND_USER,
    output logic [ADDR_W-1:0] ADDRESS_USER,
    output logic [BANK_W-1:0] BANK_USER,
    output logic              RW_STROBE,
    output logic              RW_IS_WRITE,
    output logic              REF_OVERRUN
);

    localparam logic [TMR_W-1:0] RCD_LAST = TMR_W'(T_RCD - 1);
    localparam logic [TMR_W-1:0] RC_LAST  = TMR_W'(T_RC - 1);
    localparam logic [TMR_W-1:0] RFC_LAST = TMR_W'(T_RFC - 1);

    state_t             state_q, state_d;
    logic [TMR_W-1:0]   tmr_q, tmr_d;
    logic [2:0]         cmd_d;
    logic [ADDR_W-1:0]  addr_d;
    logic [BANK_W-1:0]  bank_d;
    logic               strobe_d, wr_d, ready_d;
    logic               accept, go_next, capture, ref_clr, pend_d;
    logic               ref_wrap, ref_pending;
    logic [ROW_W-1:0]   req_row_q;
    logic [BANK_W-1:0]  req_bank_q;
    logic [COL_W-1:0]   req_col_q;
    logic               req_we_q;

    sdram_refresh_timer #(
        .T_REFI (T_REFI)
    ) u_refresh_timer (
        .CLK_n   (CLK_n),
        .RST     (RST),
        .enable  (INIT_DONE),
        .clear   (ref_clr),
        .wrap    (ref_wrap),
        .pending (ref_pending),
        .overrun (REF_OVERRUN)
    );

    assign accept  = REQ_VALID && REQ_READY && INIT_DONE;
    assign ref_clr = (state_d == ST_REF);
    assign pend_d  = ref_wrap || (ref_pending && !ref_clr);

    always_comb begin
        state_d  = state_q;
        tmr_d    = tmr_q + 1'b1;
        cmd_d    = CMD_NOOP;
        addr_d   = ADDRESS_USER;
        bank_d   = BANK_USER;
        strobe_d = 1'b0;
        wr_d     = 1'b0;
        go_next  = 1'b0;
        capture  = 1'b0;
        case (state_q)
            ST_IDLE:                 go_next = 1'b1;
            ST_ACT, ST_RCD_WAIT: begin
                if (tmr_q == RCD_LAST) begin
                    state_d  = ST_RW;
                    cmd_d    = req_we_q ? CMD_WRIT : CMD_READ;
                    addr_d   = rw_address(req_col_q);
                    bank_d   = req_bank_q;
                    strobe_d = 1'b1;
                    wr_d     = req_we_q;
                end else begin
                    state_d = ST_RCD_WAIT;
                end
            end
            ST_RW:                   state_d = ST_RC_WAIT;
            ST_RC_WAIT:              go_next = (tmr_q == RC_LAST);
            ST_REF:                  state_d = ST_RFC_WAIT;
            ST_RFC_WAIT:             go_next = (tmr_q == RFC_LAST);
            default:                 state_d = ST_IDLE;
        endcase
        // Refresh outranks a request; READY was already low while it was pending.
        if (go_next) begin
            state_d = ST_IDLE;
            if (INIT_DONE && ref_pending) begin
                state_d = ST_REF;
                tmr_d   = '0;
                cmd_d   = CMD_ARSR;
                addr_d  = ARSR_ADDR;
            end else if (accept) begin
                state_d = ST_ACT;
                tmr_d   = '0;
                cmd_d   = CMD_ACTV;
                addr_d  = REQ_ADDR[REQ_W-1 -: ROW_W];
                bank_d  = REQ_ADDR[COL_W +: BANK_W];
                capture = 1'b1;
            end
        end
        ready_d = INIT_DONE && !pend_d &&
                  ((state_d == ST_IDLE) ||
                   ((state_d == ST_RC_WAIT)  && (tmr_d == RC_LAST)) ||
                   ((state_d == ST_RFC_WAIT) && (tmr_d == RFC_LAST)));
    end

    always_ff @(posedge CLK_n) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            tmr_q        <= '0;
            COMMAND_USER <= CMD_NOOP;
            ADDRESS_USER <= '0;
            BANK_USER    <= '0;
            REQ_READY    <= 1'b0;
            RW_STROBE    <= 1'b0;
            RW_IS_WRITE  <= 1'b0;
        end else begin
            state_q      <= state_d;
            tmr_q        <= tmr_d;
            COMMAND_USER <= cmd_d;
            ADDRESS_USER <= addr_d;
            BANK_USER    <= bank_d;
            REQ_READY    <= ready_d;
            RW_STROBE    <= strobe_d;
            RW_IS_WRITE  <= wr_d;
        end
    end

    always_ff @(posedge CLK_n) begin
        if (capture) begin
            req_row_q  <= REQ_ADDR[REQ_W-1 -: ROW_W];
            req_bank_q <= REQ_ADDR[COL_W +: BANK_W];
            req_col_q  <= REQ_ADDR[COL_W-1:0];
            req_we_q   <= REQ_WE;
        end
    end

endmodule
